// File: rtl/bcd_display_scan_ctrl.sv
// rtl/bcd_display_scan_ctrl.sv - serial binary-to-BCD converter with multiplexed 7-segment scan
module bcd_display_scan_ctrl #(
    parameter int SCAN_DIV = 1000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [8:0]  bin_in,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd_out,
    output logic [6:0]  seg,
    output logic [2:0]  dig_en
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CONV  = 2'd1;
    localparam logic [1:0] ST_LATCH = 2'd2;

    localparam int             PW      = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]  PS_LAST = PW'(SCAN_DIV - 1);

    logic [1:0]    state_q, state_d;
    logic [8:0]    bin_q, bin_d;
    logic [11:0]   scratch_q, scratch_d;
    logic [3:0]    iter_q, iter_d;
    logic [11:0]   bcd_q, bcd_d;
    logic          done_q, done_d;
    logic [PW-1:0] ps_q, ps_d;
    logic [1:0]    idx_q, idx_d;
    logic [6:0]    seg_q, seg_d;
    logic [2:0]    dig_en_q, dig_en_d;

    logic [11:0]   adj;
    logic [3:0]    nib;
    logic          blank;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1111110;
            4'd1:    seg7 = 7'b0110000;
            4'd2:    seg7 = 7'b1101101;
            4'd3:    seg7 = 7'b1111001;
            4'd4:    seg7 = 7'b0110011;
            4'd5:    seg7 = 7'b1011011;
            4'd6:    seg7 = 7'b1011111;
            4'd7:    seg7 = 7'b1110000;
            4'd8:    seg7 = 7'b1111111;
            4'd9:    seg7 = 7'b1111011;
            default: seg7 = 7'b0000000;
        endcase
    endfunction

    // Add-3 correction on each scratch nibble before the shift.
    always_comb begin
        adj[3:0]   = (scratch_q[3:0]   >= 4'd5) ? scratch_q[3:0]   + 4'd3 : scratch_q[3:0];
        adj[7:4]   = (scratch_q[7:4]   >= 4'd5) ? scratch_q[7:4]   + 4'd3 : scratch_q[7:4];
        adj[11:8]  = (scratch_q[11:8]  >= 4'd5) ? scratch_q[11:8]  + 4'd3 : scratch_q[11:8];
    end

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        scratch_d = scratch_q;
        iter_d    = iter_q;
        bcd_d     = bcd_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    bin_d     = bin_in;
                    scratch_d = '0;
                    iter_d    = '0;
                    state_d   = ST_CONV;
                end
            end
            ST_CONV: begin
                scratch_d = {adj[10:0], bin_q[8]};
                bin_d     = {bin_q[7:0], 1'b0};
                iter_d    = iter_q + 4'd1;
                if (iter_q == 4'd8) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                bcd_d   = scratch_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // seg/dig_en are loaded from the next index so both switch together.
    always_comb begin
        ps_d  = ps_q + 1'b1;
        idx_d = idx_q;
        if (ps_q == PS_LAST) begin
            ps_d  = '0;
            idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end
        nib   = bcd_q[3:0];
        blank = 1'b0;
        case (idx_d)
            2'd2: begin
                nib   = bcd_q[11:8];
                blank = BLANK_LZ && (bcd_q[11:8] == 4'd0);
            end
            2'd1: begin
                nib   = bcd_q[7:4];
                blank = BLANK_LZ && (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
            end
            default: begin
                nib   = bcd_q[3:0];
                blank = 1'b0;
            end
        endcase
        seg_d    = blank ? 7'b0000000 : seg7(nib);
        dig_en_d = 3'b001 << idx_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bin_q     <= '0;
            scratch_q <= '0;
            iter_q    <= '0;
            bcd_q     <= '0;
            done_q    <= 1'b0;
            ps_q      <= '0;
            idx_q     <= '0;
            seg_q     <= 7'b1111110;
            dig_en_q  <= 3'b001;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            iter_q    <= iter_d;
            bcd_q     <= bcd_d;
            done_q    <= done_d;
            ps_q      <= ps_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            dig_en_q  <= dig_en_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign bcd_out = bcd_q;
    assign seg     = seg_q;
    assign dig_en  = dig_en_q;

endmodule

// File: tb/tb_bcd_display_scan_ctrl.sv
// tb/tb_bcd_display_scan_ctrl.sv - scoreboard bench for bcd_display_scan_ctrl
module tb_bcd_display_scan_ctrl;

    localparam int SD = 4;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        load   = 1'b0;
    logic [8:0]  bin_in = '0;

    logic        busy, done, busy1, done1;
    logic [11:0] bcd, bcd1;
    logic [6:0]  seg, seg1;
    logic [2:0]  den, den1;

    always #5 clk = ~clk;

    bcd_display_scan_ctrl #(.SCAN_DIV(SD), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .load(load),
        .busy(busy), .done(done), .bcd_out(bcd), .seg(seg), .dig_en(den)
    );

    bcd_display_scan_ctrl #(.SCAN_DIV(SD), .BLANK_LZ(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .load(load),
        .busy(busy1), .done(done1), .bcd_out(bcd1), .seg(seg1), .dig_en(den1)
    );

    int total = 0;
    int bad   = 0;

    int exp_arr [1024];
    int wr = 0, rd = 0;
    int m_cnt = 0, m_pend = 0, m_disp = 0, m_src = 0, n = 0;
    bit m_done = 1'b0;
    bit fin = 1'b0, fin_seen = 1'b0;

    function automatic int to_bcd(input int v);
        return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    function automatic int dec7(input int d);
        case (d)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 0;
        endcase
    endfunction

    function automatic int exp_seg(input int v, input int dig, input bit blz);
        int h, t, o;
        h = (v >> 8) & 15;
        t = (v >> 4) & 15;
        o = v & 15;
        if (dig == 2) return (blz && h == 0) ? 0 : dec7(h);
        if (dig == 1) return (blz && h == 0 && t == 0) ? 0 : dec7(t);
        return dec7(o);
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference model: cycle-level view of acceptance, busy window and latch.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr     = 0;
            m_cnt  = 0;
            m_disp = 0;
            m_src  = 0;
            n      = 0;
            m_done = 1'b0;
        end else begin
            m_src  = m_disp;
            m_done = 1'b0;
            n++;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_done = 1'b1;
                    m_disp = m_pend;
                end
            end else if (load) begin
                m_pend = to_bcd(int'(bin_in));
                if (wr < 1024) exp_arr[wr] = m_pend;
                wr++;
                m_cnt = 10;
            end
        end
    end

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd = 0;
            if (!clk) begin
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_bcd", bcd, 0);
                chk("rst_dig_en", den, 1);
                chk("rst_seg", seg, 7'b1111110);
                chk("rst_done_nb", done1, 0);
                chk("rst_seg_nb", seg1, 7'b1111110);
            end
        end else begin
            int dig;
            chk("busy", busy, (m_cnt > 0) ? 1 : 0);
            chk("done", done, m_done ? 1 : 0);
            if (done) begin
                if (rd < wr && rd < 1024) begin
                    chk("done_value", bcd, exp_arr[rd]);
                end else begin
                    total++;
                    bad++;
                    $display("FAIL done_unexpected: got done=1 with %0d pending (t=%0t)", wr - rd, $time);
                end
                rd++;
            end
            chk("bcd_out", bcd, m_disp);
            chk("busy_nb", busy1, (m_cnt > 0) ? 1 : 0);
            chk("bcd_out_nb", bcd1, m_disp);
            dig = (n / SD) % 3;
            chk("dig_en", den, 1 << dig);
            chk("dig_en_nb", den1, 1 << dig);
            chk("seg", seg, exp_seg(m_src, dig, 1'b1));
            chk("seg_nb", seg1, exp_seg(m_src, dig, 1'b0));
            if (fin && !fin_seen) begin
                fin_seen = 1'b1;
                chk("drain", rd, wr);
            end
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int v);
        load   = 1'b1;
        bin_in = 9'(v);
        cyc(1);
        load   = 1'b0;
    endtask

    initial begin
        cyc(3);
        rst_n = 1'b1;
        cyc(3 * SD);

        do_load(511); cyc(24);
        do_load(105); cyc(24);
        do_load(7);   cyc(24);

        do_load(300); cyc(4);
        do_load(42);  cyc(24);

        do_load(255); cyc(5);
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(4);

        do_load(9); cyc(24);

        for (int v = 0; v < 512; v++) begin
            do_load(v);
            cyc(10);
        end

        repeat (150) begin
            do_load(int'($urandom % 512));
            cyc(int'($urandom_range(0, 14)));
        end

        cyc(30);
        fin = 1'b1;
        cyc(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
